// File: rtl/fsm_ones_sched_if.sv
// Bus between the ones-detector scheduler, its serial requesters and the shared detector.
// Carries requests, grants, detector hookup, the per-frame result and a debug view of the FSM state.
interface fsm_ones_sched_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Transfer rule: a bit (with its last flag) moves in every cycle gnt[c] is high;
  // req[c] is the valid side and stays up until that channel's last has moved.
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  bit_in;
  logic [N_CH-1:0]  last;
  logic [N_CH-1:0]  gnt;
  logic             det_data;
  logic             det_reset_n;
  logic             det_detect;
  logic             hit_valid;
  logic [CH_W-1:0]  hit_ch;
  logic [CNT_W-1:0] hit_count;
  logic             hit_err;
  logic             busy;
  logic [2:0]       dbg_state;

  modport master (
    input  req, bit_in, last, det_detect,
    output gnt, det_data, det_reset_n, hit_valid, hit_ch, hit_count, hit_err, busy, dbg_state
  );

  modport slave (
    output req, bit_in, last, det_detect,
    input  gnt, det_data, det_reset_n, hit_valid, hit_ch, hit_count, hit_err, busy, dbg_state
  );
endinterface

// File: rtl/fsm_ones_sched.sv
// Round-robin scheduler sharing one three-ones Moore detector among N_CH serial requesters.
// Optional frame watchdog (MAX_LEN bits) is enabled by defining FSM_SCHED_TIMEOUT_EN.
module fsm_ones_sched #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  fsm_ones_sched_if.master   bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0]   N_CH_V = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, REPORT} state_t;

  if (MAX_LEN < 1) begin : g_len_chk
    $error("MAX_LEN must be at least 1");
  end

  state_t           state, state_nx;
  logic [CH_W-1:0]  ptr, cur, pick;
  logic             pick_ok;
  logic [CH_W:0]    sum;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc;
  logic             det_rst_n_q;
  logic [N_CH-1:0]  gnt;
  logic             det_data;

  // First requester at or after ptr; scanning downward lets the nearest one win.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (CH_W + 1)'(i);
      if (sum >= N_CH_V) sum = sum - N_CH_V;
      if (bus.req[sum[CH_W-1:0]]) begin
        pick    = sum[CH_W-1:0];
        pick_ok = 1'b1;
      end
    end
  end

`ifdef FSM_SCHED_TIMEOUT_EN
  localparam int BCNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic [BCNT_W-1:0] bcnt;
  logic              timeout;
  logic              err;
`endif

  always_comb begin
    state_nx = state;
    gnt      = '0;
    det_data = 1'b0;
    cnt_inc  = 1'b0;
`ifdef FSM_SCHED_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state)
      IDLE:   if (pick_ok) state_nx = CLR;
      CLR:    state_nx = RUN;
      RUN: begin
        gnt[cur] = 1'b1;
        det_data = bus.bit_in[cur];
        cnt_inc  = bus.det_detect;
        if (bus.last[cur]) begin
          state_nx = DRAIN;
        end
`ifdef FSM_SCHED_TIMEOUT_EN
        else if (bcnt == BCNT_W'(MAX_LEN - 1)) begin
          state_nx = DRAIN;
          timeout  = 1'b1;
        end
`endif
      end
      // The detector answers the final bit one cycle late; DRAIN catches that answer.
      DRAIN: begin
        cnt_inc  = bus.det_detect;
        state_nx = REPORT;
      end
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      cnt         <= '0;
      det_rst_n_q <= 1'b0;
    end else begin
      state       <= state_nx;
      det_rst_n_q <= (state_nx != CLR);
      if (state == IDLE && pick_ok) begin
        cur <= pick;
        cnt <= '0;
      end
      if (cnt_inc && (cnt != '1)) cnt <= cnt + 1'b1;
      if (state == REPORT) ptr <= (cur == LAST_CH) ? '0 : cur + 1'b1;
    end
  end

`ifdef FSM_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE && pick_ok) begin
        bcnt <= '0;
        err  <= 1'b0;
      end else if (state == RUN) begin
        bcnt <= bcnt + 1'b1;
      end
      if (timeout) err <= 1'b1;
    end
  end
  assign bus.hit_err = (state == REPORT) && err;
`else
  assign bus.hit_err = 1'b0;
`endif

  assign bus.gnt         = gnt;
  assign bus.det_data    = det_data;
  assign bus.det_reset_n = det_rst_n_q;
  assign bus.hit_valid   = (state == REPORT);
  assign bus.hit_ch      = cur;
  assign bus.hit_count   = cnt;
  assign bus.busy        = (state != IDLE);
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_fsm_ones_sched.sv
// Bench for fsm_ones_sched: behavioural detector, frame-schedule model and result scoreboard.
// Works with or without FSM_SCHED_TIMEOUT_EN defined.
module tb_fsm_ones_sched;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 3;
  localparam int MAX_LEN = 8;
  localparam int CH_W    = 2;
  localparam int W       = 1 + CH_W + CNT_W;
  localparam int MAXB    = 64;
`ifdef FSM_SCHED_TIMEOUT_EN
  localparam int TO_LEN = MAX_LEN;
`else
  localparam int TO_LEN = 100000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fsm_ones_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  fsm_ones_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shared detector: detect is high while the last three accepted bits were ones.
  int det_ones = 0;
  always_ff @(posedge clk) begin
    if (!bus.det_reset_n) det_ones <= 0;
    else if (bus.det_data) det_ones <= (det_ones < 3) ? det_ones + 1 : 3;
    else det_ones <= 0;
  end
  assign bus.det_detect = (det_ones == 3);

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [MAXB-1:0] fbits [N_CH];
  int flen [N_CH];
  int fpos [N_CH];
  int nfr  [N_CH];
  logic [W-1:0] exp_q [$];
  int got_order [$];
  int cyc = 0;
  int a_cyc = 0;
  int s_ch = 0;
  int s_len = 0;
  logic s_trunc = 1'b0;
  logic in_frame = 1'b0;
  int ptr_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_hits(input logic [MAXB-1:0] b, input int len);
    int h = 0;
    for (int k = 2; k < len; k++) if (b[k] && b[k-1] && b[k-2]) h++;
    if (h > (1 << CNT_W) - 1) h = (1 << CNT_W) - 1;
    return h;
  endfunction

  function automatic int arb(input logic [N_CH-1:0] r, input int p);
    for (int i = 0; i < N_CH; i++) if (r[(p + i) % N_CH]) return (p + i) % N_CH;
    return 0;
  endfunction

  function automatic logic pending();
    for (int c = 0; c < N_CH; c++) if (fpos[c] < flen[c] || nfr[c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_str(input int c, input string s);
    fbits[c] = '0;
    for (int i = 0; i < s.len(); i++) fbits[c][i] = (s[i] == 8'h31);
    flen[c] = s.len();
    fpos[c] = 0;
    nfr[c]  = 0;
  endtask

  task automatic new_rand_frame(input int c);
    fbits[c] = {$urandom, $urandom} | {$urandom, $urandom};
    flen[c]  = $urandom_range(1, 12);
    fpos[c]  = 0;
  endtask

  task automatic load_rand(input int c, input int extra);
    new_rand_frame(c);
    nfr[c] = extra;
  endtask

  task automatic clear_model();
    in_frame = 1'b0;
    exp_q.delete();
    ptr_m = 0;
    for (int c = 0; c < N_CH; c++) begin
      flen[c] = 0;
      fpos[c] = 0;
      nfr[c]  = 0;
    end
    bus.req = '0;
  endtask

  // One clock: check outputs against the frame schedule, then drive the next inputs.
  task automatic step();
    int rel;
    logic was_idle, g_now, at_rep, drv_bit;
    logic [N_CH-1:0] oh;
    @(negedge clk);
    cyc++;
    was_idle = !in_frame;
    rel    = in_frame ? (cyc - a_cyc) : -1;
    g_now  = in_frame && rel >= 2 && rel <= s_len + 1;
    at_rep = in_frame && rel == s_len + 3;
    oh = '0;
    if (g_now) oh[s_ch] = 1'b1;
    chk("gnt", bus.gnt, oh);
    chk("busy", bus.busy, in_frame && rel >= 1);
    chk("det_reset_n", bus.det_reset_n, !(in_frame && rel == 1));
    chk("hit_valid", bus.hit_valid, at_rep);
    if (at_rep) begin
      if (exp_q.size() > 0) chk("hit_result", {bus.hit_err, bus.hit_ch, bus.hit_count}, exp_q.pop_front());
      got_order.push_back(int'(bus.hit_ch));
      ptr_m = (s_ch + 1) % N_CH;
      if (s_trunc) fpos[s_ch] = flen[s_ch];
      in_frame = 1'b0;
    end

    for (int c = 0; c < N_CH; c++)
      if (fpos[c] >= flen[c] && nfr[c] > 0) begin
        new_rand_frame(c);
        nfr[c]--;
      end
    drv_bit = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      bus.req[c] = (fpos[c] < flen[c]);
      if (g_now && c == s_ch) begin
        drv_bit = fbits[c][fpos[c]];
        bus.bit_in[c] = drv_bit;
        bus.last[c]   = (fpos[c] == flen[c] - 1);
        fpos[c]++;
      end else begin
        bus.bit_in[c] = 1'($urandom_range(0, 1));
        bus.last[c]   = 1'($urandom_range(0, 1));
      end
    end

    if (was_idle && bus.req != '0) begin
      s_ch    = arb(bus.req, ptr_m);
      a_cyc   = cyc;
      s_trunc = (flen[s_ch] > TO_LEN);
      s_len   = s_trunc ? TO_LEN : flen[s_ch];
      exp_q.push_back({s_trunc, CH_W'(s_ch), CNT_W'(exp_hits(fbits[s_ch], s_len))});
      in_frame = 1'b1;
    end
    #1;
    chk("det_data", bus.det_data, g_now ? drv_bit : 1'b0);
  endtask

  task automatic run_until_idle(input int budget);
    logic idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      step();
      idle = !in_frame && !pending();
    end
    chk("idle_reached", idle, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    chk("busy_in_reset", bus.busy, 1'b0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ord_a [4] = '{0, 2, 0, 2};
    logic found;
    bus.req = '0;
    bus.bit_in = '0;
    bus.last = '0;
    clear_model();

    @(negedge clk);
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_det_data", bus.det_data, 1'b0);
    chk("rst_det_reset_n", bus.det_reset_n, 1'b0);
    chk("rst_hit_valid", bus.hit_valid, 1'b0);
    chk("rst_hit_ch", bus.hit_ch, '0);
    chk("rst_hit_count", bus.hit_count, '0);
    chk("rst_hit_err", bus.hit_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step();

    // Directed frames
    load_str(0, "111");          run_until_idle(20);
    load_str(1, "111111");       run_until_idle(20);
    load_str(2, "110");          run_until_idle(20);
    load_str(2, "10101010");     run_until_idle(20);
    load_str(3, "1101110110");   run_until_idle(30);
    load_str(1, "1");            run_until_idle(20);
    load_str(0, "111111111111"); run_until_idle(30);
    load_str(1, "11111111");     run_until_idle(30);
    load_str(0, "1111111111");   run_until_idle(30);

    // Continuous requesters: strict rotation from ptr 0
    do_reset();
    got_order.delete();
    load_rand(0, 1);
    load_rand(2, 1);
    run_until_idle(200);
    chk("order_len", got_order.size(), 4);
    for (int i = 0; i < 4 && i < got_order.size(); i++) chk("order_a", got_order[i], ord_a[i]);
    for (int c = 0; c < N_CH; c++) load_rand(c, 2);
    run_until_idle(400);

    // Random traffic
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 1) == 1) load_rand(c, $urandom_range(0, 1));
      if (!pending()) load_rand($urandom_range(0, N_CH - 1), 0);
      run_until_idle(400);
    end

    // Reset on the second bit of a frame
    load_str(2, "1111");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (in_frame && (cyc - a_cyc) == 3) found = 1'b1;
    end
    chk("reached_bit2", found, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.gnt, '0);
    chk("mid_rst_det_reset_n", bus.det_reset_n, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_hit_valid", bus.hit_valid, 1'b0);
    clear_model();
    repeat (3) begin
      @(negedge clk);
      chk("hit_valid_in_reset", bus.hit_valid, 1'b0);
    end
    reset = 1'b0;
    run_until_idle(5);
    load_str(1, "0111");
    run_until_idle(20);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, observed running expected done");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/fsm_ones_sched.md
# fsm_ones_sched

Round-robin scheduler that shares one three-consecutive-ones Moore detector (`fsm_ones_moore_2`) among `N_CH` serial requesters. It clears the detector before each frame and multiplexes the granted channel's bit stream onto the detector input. It counts detection cycles over the frame and reports one result per frame. It sits between the serial sources and the single detector instance.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels.
- `CNT_W`, 8: width of the hit counter.
- `MAX_LEN`, 64: watchdog frame length in bits; used only with `FSM_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all registers on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_CH  per-channel frame request; held until the channel's `last` is accepted.
- `bit_in`  in  N_CH  per-channel serial data bit.
- `last`  in  N_CH  marks the final bit of the frame; valid only while granted.
- `gnt`  out  N_CH  one-hot grant; a bit is consumed in every cycle `gnt` is high.
- `det_data`  out  1  to detector `data_in`.
- `det_reset_n`  out  1  to detector `reset`, active-low, registered.
- `det_detect`  in  1  from detector `detect`.
- `hit_valid`  out  1  one-cycle result strobe.
- `hit_ch`  out  $clog2(N_CH)  channel index of the reported frame.
- `hit_count`  out  CNT_W  detection cycles counted in the frame.
- `hit_err`  out  1  frame was aborted by the watchdog.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, CLR, RUN, DRAIN, REPORT.
- **IDLE**
  - If `req` is nonzero, select the first requesting channel at or after pointer `ptr`, searching upward with wrap.
  - Latch the selection as `cur`, zero the counter, go to CLR.
- **CLR** (1 cycle)
  - `det_reset_n` is 0 during this cycle; `gnt` is 0; `det_data` is 0.
  - Go to RUN.
- **RUN**
  - `gnt[cur]` is 1 and `det_data` = `bit_in[cur]`. One bit is transferred per cycle.
  - If `det_detect` is 1, increment the counter.
  - When `last[cur]` is 1, go to DRAIN.
  - `req` dropping mid-frame is ignored; only `last` ends a frame.
- **DRAIN** (1 cycle)
  - `gnt` is 0 and `det_data` is 0.
  - Count `det_detect`; this captures the detector's response to the final bit.
- **REPORT** (1 cycle)
  - `hit_valid` is 1, `hit_ch` = `cur`, and `hit_count` is the counter value.
  - Set `ptr` = (`cur`+1) mod `N_CH`. Go to IDLE.
- **Counter:** saturates at 2^CNT_W−1 and never wraps.
- **Idle outputs:** `det_data` is 0 whenever the block is not in RUN. `det_reset_n` is 1 in every state except CLR and reset.
- **Overlap:** one detection is counted per cycle `detect` is high, so overlapping runs count. Example: six consecutive ones yield 4.

## Timing
- **Reset values:**
  - State IDLE, `ptr`=0.
  - `gnt`=0, `det_data`=0, `det_reset_n`=0.
  - `hit_valid`=0, `hit_ch`=0, `hit_count`=0, `hit_err`=0, `busy`=0.
- **Reset release:** `det_reset_n` rises at the first clock edge after reset deasserts.
- **Frame sequence:** `req` seen in IDLE at edge t. CLR occupies cycle t+1. The first bit is granted in cycle t+2.
- **Frame length:** an L-bit frame occupies L RUN cycles, then DRAIN, then REPORT. `hit_valid` is high L+3 cycles after arbitration.
- **Back-to-back frames:** the earliest next arbitration is the IDLE cycle after REPORT, so there is a 1-cycle gap in which `busy` is 0.
- **Simultaneous requests:** resolved by `ptr`. A continuously requesting set is served in strict rotation.
- **Reset mid-frame:** asynchronous return to IDLE with reset values. No `hit_valid` is produced for the aborted frame.

## Configuration
- **`FSM_SCHED_TIMEOUT_EN` defined:**
  - RUN counts bits. If `MAX_LEN` bits have been transferred without `last`, go to DRAIN and set `hit_err`=1 in REPORT.
  - The requester's remaining bits and `last` are ignored until its next grant.
  - Normal frames report `hit_err`=0.
- **Not defined:** no bit counter, frames are unbounded, and `hit_err` is tied to 0.

## Test plan
- ch0 sends frame `111` with `last` on the third bit -> `gnt[0]` high 3 cycles, then `hit_valid` with `hit_ch`=0, `hit_count`=1.
- ch1 sends six ones -> `hit_count`=4. ch2 sends `110` -> 0. ch2 sends `10101010` -> 0.
- ch3 sends `1101110110` -> `hit_count`=1. `det_reset_n` is low exactly one cycle before the first bit.
- ch0 and ch2 request continuously after reset -> grants alternate 0, 2, 0, 2. Then ch1 and ch3 are added -> order 0, 1, 2, 3.
- Reset asserted on the 2nd bit of a frame -> `gnt`=0, `det_reset_n`=0, `busy`=0 immediately, and no `hit_valid`. After release, a new frame reports correctly.
- With `FSM_SCHED_TIMEOUT_EN` and `MAX_LEN`=8, ch0 sends 10 ones without `last` -> after 8 bits, DRAIN, then `hit_err`=1 and `hit_count`=6.
